// File: rtl/wren_other_arbiter_if.sv
// Request/grant bundle between the accelerators and the write-enable arbiter.
// The master side is the accelerator pool; the slave side is the arbiter.
interface wren_other_arbiter_if #(
    parameter int REQ_COUNT         = 4,
    parameter int REQ_ADDR_WIDTH    = 2,
    parameter int THREAD_ADDR_WIDTH = 3
);
    logic [REQ_COUNT-1:0]         req;
    logic [2*REQ_COUNT-1:0]       req_target;
    logic [REQ_COUNT-1:0]         grant;
    logic                         grant_valid;
    logic [REQ_ADDR_WIDTH-1:0]    grant_id;
    logic [THREAD_ADDR_WIDTH-1:0] slot;
    logic                         round_start;
    logic                         I_wren_other;
    logic                         A_wren_other;
    logic                         B_wren_other;

    modport master (
        output req, req_target,
        input  grant, grant_valid, grant_id, slot, round_start,
        input  I_wren_other, A_wren_other, B_wren_other
    );

    modport slave (
        input  req, req_target,
        output grant, grant_valid, grant_id, slot, round_start,
        output I_wren_other, A_wren_other, B_wren_other
    );
endinterface

// File: rtl/wren_other_arbiter.sv
// Round-robin arbiter for the Scalar core's I/A/B external write enables.
// Grants begin and end only on thread-round boundaries (slot wrap), so an
// accelerator always owns whole rounds of every thread.
module wren_other_arbiter #(
    parameter int REQ_COUNT         = 4,
    parameter int REQ_ADDR_WIDTH    = 2,
    parameter int THREAD_COUNT      = 8,
    parameter int THREAD_ADDR_WIDTH = 3,
    parameter int HOLD_ROUNDS       = 1
) (
    input  logic                 clock,
    input  logic                 reset,
    wren_other_arbiter_if.slave  bus
);
    localparam int RL_WIDTH = $clog2(HOLD_ROUNDS + 1);
    localparam logic [THREAD_ADDR_WIDTH-1:0] SLOT_LAST = THREAD_ADDR_WIDTH'(THREAD_COUNT - 1);
    localparam logic [RL_WIDTH-1:0]          RL_INIT   = RL_WIDTH'(HOLD_ROUNDS);
    localparam logic [RL_WIDTH-1:0]          RL_ONE    = RL_WIDTH'(1);
    localparam logic [1:0] TGT_I    = 2'd0;
    localparam logic [1:0] TGT_A    = 2'd1;
    localparam logic [1:0] TGT_B    = 2'd2;
    localparam logic [1:0] TGT_NONE = 2'd3;

    typedef enum logic {ST_IDLE, ST_GRANT} state_t;

    state_t                       state_reg, state_next;
    logic [THREAD_ADDR_WIDTH-1:0] slot_reg, slot_next;
    logic [REQ_ADDR_WIDTH-1:0]    gid_reg, gid_next;
    logic [REQ_ADDR_WIDTH-1:0]    ptr_reg, ptr_next;
    logic [1:0]                   tgt_reg, tgt_next;
    logic [RL_WIDTH-1:0]          rl_reg, rl_next;
    logic                         i_wren_reg, i_wren_next;
    logic                         a_wren_reg, a_wren_next;
    logic                         b_wren_reg, b_wren_next;

    logic [REQ_COUNT-1:0]         eligible;
    logic [1:0]                   target [REQ_COUNT];
    logic                         win_found;
    logic [REQ_ADDR_WIDTH-1:0]    win_id;
    logic                         arb_point;

    // Per-requester target decode; target 3 makes a request invisible.
    generate
        for (genvar gi = 0; gi < REQ_COUNT; gi++) begin : g_req
            assign target[gi]   = bus.req_target[2*gi +: 2];
            assign eligible[gi] = bus.req[gi] && (target[gi] != TGT_NONE);
        end
    endgenerate

    assign arb_point = (slot_reg == SLOT_LAST);

    // Rotating search: first eligible requester at or after the pointer.
    always_comb begin
        logic [REQ_ADDR_WIDTH-1:0] idx;
        idx       = '0;
        win_found = 1'b0;
        win_id    = '0;
        for (int i = 0; i < REQ_COUNT; i++) begin
            idx = REQ_ADDR_WIDTH'((int'(ptr_reg) + i) % REQ_COUNT);
            if (!win_found && eligible[idx]) begin
                win_found = 1'b1;
                win_id    = idx;
            end
        end
    end

    // State register: FSM state, slot counter, latched grant and enables.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg  <= ST_IDLE;
            slot_reg   <= '0;
            gid_reg    <= '0;
            ptr_reg    <= '0;
            tgt_reg    <= TGT_I;
            rl_reg     <= '0;
            i_wren_reg <= 1'b0;
            a_wren_reg <= 1'b0;
            b_wren_reg <= 1'b0;
        end else begin
            state_reg  <= state_next;
            slot_reg   <= slot_next;
            gid_reg    <= gid_next;
            ptr_reg    <= ptr_next;
            tgt_reg    <= tgt_next;
            rl_reg     <= rl_next;
            i_wren_reg <= i_wren_next;
            a_wren_reg <= a_wren_next;
            b_wren_reg <= b_wren_next;
        end
    end

    // Next state: decisions happen only at the last slot of a round; the
    // enables are precomputed from the post-edge grant and the live request.
    always_comb begin
        state_next = state_reg;
        gid_next   = gid_reg;
        ptr_next   = ptr_reg;
        tgt_next   = tgt_reg;
        rl_next    = rl_reg;
        slot_next  = arb_point ? '0 : slot_reg + 1'b1;

        if (arb_point) begin
            if (state_reg == ST_GRANT && bus.req[gid_reg] && rl_reg > RL_ONE) begin
                // Holder keeps the bus for another round.
                rl_next = rl_reg - RL_ONE;
            end else if (win_found) begin
                // Pointer already sits past the holder, so the holder only
                // wins again when nobody else is eligible.
                state_next = ST_GRANT;
                gid_next   = win_id;
                tgt_next   = target[win_id];
                rl_next    = RL_INIT;
                ptr_next   = REQ_ADDR_WIDTH'((int'(win_id) + 1) % REQ_COUNT);
            end else begin
                state_next = ST_IDLE;
                gid_next   = '0;
            end
        end

        i_wren_next = (state_next == ST_GRANT) && bus.req[gid_next] && (tgt_next == TGT_I);
        a_wren_next = (state_next == ST_GRANT) && bus.req[gid_next] && (tgt_next == TGT_A);
        b_wren_next = (state_next == ST_GRANT) && bus.req[gid_next] && (tgt_next == TGT_B);
    end

    // Outputs: decoded purely from registers, no input-to-output path.
    always_comb begin
        bus.grant        = '0;
        bus.grant_valid  = (state_reg == ST_GRANT);
        bus.grant_id     = gid_reg;
        if (state_reg == ST_GRANT) begin
            bus.grant[gid_reg] = 1'b1;
        end
        bus.slot         = slot_reg;
        bus.round_start  = (slot_reg == '0);
        bus.I_wren_other = i_wren_reg;
        bus.A_wren_other = a_wren_reg;
        bus.B_wren_other = b_wren_reg;
    end
endmodule
